// File: rtl/accumulate_pkg.sv
// Shared types and helpers for the streaming saturating accumulator.
package accumulate_pkg;

  // Two-state control: collecting samples, or holding a finished result.
  typedef enum logic {
    ACCUM = 1'b0,
    DONE  = 1'b1
  } state_e;

  // Sample counter width: max(1, clog2(count)).
  function automatic int unsigned cnt_width(input int unsigned count);
    int unsigned w;
    w = $clog2(count);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/accumulate_saturate.sv
// saturate: clamps a signed WIDTH+1-bit value into the signed WIDTH-bit
// range [LOWER, UPPER]; purely combinational.
//   data_i   : signed WIDTH+1-bit input value
//   data_c_o : signed WIDTH-bit clamped value
module saturate #(
  parameter int unsigned WIDTH = 16,
  parameter logic signed [WIDTH:0] UPPER = {2'b00, {(WIDTH-1){1'b1}}},
  parameter logic signed [WIDTH:0] LOWER = {2'b11, {(WIDTH-1){1'b0}}}
) (
  input  logic signed [WIDTH:0]   data_i,
  output logic signed [WIDTH-1:0] data_c_o
);

  always_comb begin
    data_c_o = data_i[WIDTH-1:0];
    if (data_i > UPPER) begin
      data_c_o = UPPER[WIDTH-1:0];
    end else if (data_i < LOWER) begin
      data_c_o = LOWER[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/accumulate.sv
// accumulate: sums groups of COUNT signed WIDTH-bit samples into one signed
// WIDTH-bit result, clamping the running sum after every addition.
//   clk, rst_n     : clock, asynchronous active-low reset
//   arg_valid_i    : input sample present
//   arg_data_i     : signed input sample
//   arg_ready_o    : sample accepted this cycle (ACCUM state)
//   res_valid_o    : result present (DONE state)
//   res_data_o     : signed saturated sum
//   res_sat_o      : some addition in this group was clamped
//   res_ready_i    : downstream accepts the result
module accumulate
  import accumulate_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned COUNT = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    arg_valid_i,
  input  logic signed [WIDTH-1:0] arg_data_i,
  output logic                    arg_ready_o,
  output logic                    res_valid_o,
  output logic signed [WIDTH-1:0] res_data_o,
  output logic                    res_sat_o,
  input  logic                    res_ready_i
);

  localparam int unsigned CNT_W = cnt_width(COUNT);
  localparam logic signed [WIDTH:0] SUM_MAX = {2'b00, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH:0] SUM_MIN = {2'b11, {(WIDTH-1){1'b0}}};

  state_e                  state_q, state_d;
  logic signed [WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    sat_q, sat_d;

  logic signed [WIDTH:0]   sum;
  logic signed [WIDTH-1:0] sum_clamped;
  logic                    clamp_hit;

  // Full-precision sum of the running total and the incoming sample.
  assign sum       = {acc_q[WIDTH-1], acc_q} + {arg_data_i[WIDTH-1], arg_data_i};
  assign clamp_hit = (sum > SUM_MAX) || (sum < SUM_MIN);

  saturate #(
    .WIDTH (WIDTH)
  ) u_saturate (
    .data_i   (sum),
    .data_c_o (sum_clamped)
  );

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    sat_d   = sat_q;
    unique case (state_q)
      ACCUM: begin
        if (arg_valid_i) begin
          acc_d = sum_clamped;
          sat_d = sat_q | clamp_hit;
          if (cnt_q == CNT_W'(COUNT - 1)) begin
            cnt_d   = '0;
            state_d = DONE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      DONE: begin
        if (res_ready_i) begin
          acc_d   = '0;
          sat_d   = 1'b0;
          state_d = ACCUM;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ACCUM;
      acc_q   <= '0;
      cnt_q   <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      sat_q   <= sat_d;
    end
  end

  // Handshake flags decode the state register only; result fields are registers.
  assign arg_ready_o = (state_q == ACCUM);
  assign res_valid_o = (state_q == DONE);
  assign res_data_o  = acc_q;
  assign res_sat_o   = sat_q;

endmodule

// File: doc/accumulate.md
# accumulate

Streaming saturating accumulator for the datapath. It sums groups of COUNT signed WIDTH-bit samples into one signed WIDTH-bit result. After every addition it clamps the running sum with the existing `saturate` block. Samples arrive on a valid/ready input stream and results leave on a valid/ready output stream, which lets it sit between a multiplier/operand source and the downstream activation/storage stage.

## Interface
Parameters:
- WIDTH, 16, sample, result and accumulator width in bits (signed, two's complement).
- COUNT, 4, samples summed per result; must be at least 1.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- arg_valid  input  1  an input sample is present.
- arg_data  input  WIDTH  signed input sample.
- arg_ready  output  1  block accepts a sample this cycle.
- res_valid  output  1  a result is present.
- res_data  output  WIDTH  signed saturated sum.
- res_sat  output  1  at least one addition in this group was clamped.
- res_ready  input  1  downstream accepts the result.

## Operation
- State machine with two states:
  - ACCUM: arg_ready=1, res_valid=0.
  - DONE: arg_ready=0, res_valid=1.
- Registers:
  - acc: WIDTH bits, signed.
  - cnt: max(1,$clog2(COUNT)) bits.
  - sat: 1 bit.
  - state.
- Input handshake (ACCUM, arg_valid=1):
  - Form sum = sign-extended acc + sign-extended arg_data at WIDTH+1 bits.
  - Pass sum through `saturate`. The clamp range is [-2^(WIDTH-1), 2^(WIDTH-1)-1].
  - acc <= clamped value.
  - sat <= sat | clamp occurred. A clamp occurred when the sum is at or above 2^(WIDTH-1), or below -2^(WIDTH-1).
  - If cnt == COUNT-1: cnt <= 0 and go to DONE. Otherwise cnt <= cnt+1.
- Saturation is applied to the running sum, not only at the end. Ordering matters: 30000+30000-30000 gives 2767, not 30000.
- DONE:
  - res_data = acc and res_sat = sat. Both are driven directly from registers.
  - Both hold stable while res_ready=0.
  - On res_ready=1: acc <= 0, sat <= 0, return to ACCUM.
- arg_valid is ignored outside ACCUM. arg_data is ignored when arg_valid=0.
- COUNT=1: every accepted sample goes straight to DONE with res_data = arg_data and res_sat = 0.

## Timing
- Reset (asynchronous assert, synchronous-edge release):
  - state=ACCUM, acc=0, cnt=0, sat=0.
  - Outputs: arg_ready=1, res_valid=0, res_data=0, res_sat=0.
- Reset asserted mid-group or in DONE discards the partial or pending result immediately. No result is emitted for it.
- Latency: res_valid rises on the cycle after the COUNT-th input handshake.
- Throughput: at best COUNT+1 cycles per result. DONE is a mandatory one-cycle bubble on the input, even when res_ready is already high on entry.
- arg_valid gaps stall accumulation with no change to acc, cnt or sat.
- res_ready high in ACCUM has no effect.
- No combinational path from arg_valid or res_ready to any output. arg_ready and res_valid are decoded from state only.

## Structure
- Shared package holds:
  - state enum (ACCUM, DONE);
  - a function for counter width, max(1,$clog2(COUNT)).
- One sub-module: an instance of `saturate`, with WIDTH passed through and default UPPER/LOWER, performing the clamp in the input path.
- Clamp detection is a compare on the WIDTH+1-bit sum, done alongside the `saturate` instance.

## Test plan
All scenarios use WIDTH=16, COUNT=4 unless noted.
- Inputs 1,2,3,4, back-to-back, res_ready=1 → res_data=10, res_sat=0, res_valid one cycle after the 4th handshake, arg_ready=1 the following cycle.
- Inputs 30000,30000,-30000,-30000 → running acc 30000, 32767, 2767, -27233; res_data=-27233, res_sat=1.
- Inputs -32768 four times → res_data=-32768, res_sat=1.
- Inputs 5,5,5,5 with res_ready=0 for 5 cycles after res_valid:
  - res_valid, res_data=20 and res_sat=0 stay stable;
  - arg_ready=0 throughout;
  - arg_valid=1 with data 99 during the stall is ignored;
  - the next group 1,1,1,1 yields 4.
- Two samples (7,7) accepted, then rst_n pulsed low mid-cycle:
  - outputs go to reset values asynchronously;
  - next group 1,1,1,1 yields res_data=4, res_sat=0.
- Inputs 2,3,4,5 with random arg_valid gaps of 0–3 cycles → res_data=14, res_sat=0. Repeat with COUNT=1 on inputs 7 and -3 → two results, 7 then -3, each with res_sat=0.
